// File: rtl/div32.sv
// -----------------------------------------------------------------------------
// div32 - sequential radix-2 restoring divider, one quotient bit per clock.
//
// Computes quotient = a / b and remainder = a % b for 32-bit operands. The
// request/result handshake is a level pair:
//   en    : held high by the requester; an operation starts when en is high
//           while the FSM is IDLE. en changes during LOAD/ITER(/FIXUP) are
//           ignored.
//   ready : registered, high for every cycle the FSM is in READY. The FSM
//           leaves READY (and ready falls) on the first edge that sees en low.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   nrst       in   1   synchronous active-low reset
//   en         in   1   level request
//   ready      out  1   result valid
//   is_signed  in   1   signed-mode select (only used with DIV32_SIGNED_EN)
//   a          in   32  dividend, sampled in LOAD
//   b          in   32  divisor, sampled in LOAD
//   quotient   out  32  quotient register
//   remainder  out  32  remainder register
//   state_o    out  3   current FSM state, for debug/observation
//
// Optional feature macro: DIV32_SIGNED_EN
//   When defined, is_signed=1 divides two's-complement operands (truncating
//   toward zero, remainder takes the dividend's sign). A FIXUP cycle follows
//   ITER in both modes, so normal latency is 34 edges without the macro and
//   35 edges with it. Divide-by-zero always skips ITER/FIXUP.
// -----------------------------------------------------------------------------
module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    output logic             ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [2:0]       state_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ITER  = 3'd2;
    localparam logic [2:0] ST_FIXUP = 3'd3;
    localparam logic [2:0] ST_READY = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef DIV32_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // Magnitudes; 0x80000000 negates to itself, which is its correct
    // unsigned magnitude.
    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // rem_q[WIDTH] is always 0 after a successful subtract or a restore.
    logic unused_bits;
    assign unused_bits = rem_q[WIDTH];
`else
    assign a_mag = a;
    assign b_mag = b;

    logic [1:0] unused_bits;
    assign unused_bits = {is_signed, rem_q[WIDTH]};
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not go negative.
    always_comb begin
        trial = {rem_q[WIDTH-1:0], q_q[WIDTH-1]} - {1'b0, div_q};
        if (!trial[WIDTH]) begin
            rem_next = trial;
            q_next   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
            q_next   = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
`ifdef DIV32_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
`ifdef DIV32_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = en ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_d = (b == '0) ? ST_READY : ST_ITER;
`ifdef DIV32_SIGNED_EN
            ST_ITER:  state_d = (cnt_q == '0) ? ST_FIXUP : ST_ITER;
            ST_FIXUP: state_d = ST_READY;
`else
            ST_ITER:  state_d = (cnt_q == '0) ? ST_READY : ST_ITER;
`endif
            ST_READY: state_d = en ? ST_READY : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic. Unlisted states (including illegal
    // encodings) hold every register.
    always_comb begin
        rem_d  = rem_q;
        div_d  = div_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        remo_d = remo_q;
`ifdef DIV32_SIGNED_EN
        qneg_d = qneg_q;
        rneg_d = rneg_q;
`endif
        case (state_q)
            ST_LOAD: begin
                q_d   = a_mag;
                div_d = b_mag;
                rem_d = '0;
                cnt_d = CW'(WIDTH - 1);
`ifdef DIV32_SIGNED_EN
                qneg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_d = is_signed & a[WIDTH-1];
`endif
                // Divide-by-zero reports the raw dividend, never its magnitude.
                if (b == '0) begin
                    quot_d = '1;
                    remo_d = a;
                end
            end
            ST_ITER: begin
                rem_d = rem_next;
                q_d   = q_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    quot_d = q_next;
                    remo_d = rem_next[WIDTH-1:0];
                end
            end
`ifdef DIV32_SIGNED_EN
            ST_FIXUP: begin
                if (qneg_q) quot_d = ~quot_q + 1'b1;
                if (rneg_q) remo_d = ~remo_q + 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // ready mirrors the registered state, so it rises on the edge entering
    // READY and falls on the edge entering IDLE.
    assign ready_d   = (state_d == ST_READY);

    assign ready     = ready_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_div32.sv
module tb_div32;

  logic        clk;
  logic        nrst;
  logic        en;
  logic        ready;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [2:0]  state_o;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef DIV32_SIGNED_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 34;
`endif
  localparam int LAT_DZ = 2;
  localparam int BOUND  = 100;

  div32 dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .ready     (ready),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .quotient  (quotient),
    .remainder (remainder),
    .state_o   (state_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Raise en with operands and count edges until ready (bounded).
  // Returns BOUND if ready never rose.
  task automatic start_and_wait(input logic [31:0] op_a, input logic [31:0] op_b,
                                input logic op_s, output int edges);
    a = op_a;
    b = op_b;
    is_signed = op_s;
    en = 1'b1;
    edges = BOUND;
    for (int i = 1; i < BOUND; i++) begin
      step();
      if (ready) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic release_en();
    en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    en = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    is_signed = 1'b0;
    step();
    step();
    nrst = 1'b1;
    tests_run++;
    if (state_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected 0", state_o);
    end
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 0", ready);
    end
    tests_run++;
    if (quotient !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_quotient: got %h expected 0", quotient);
    end
    tests_run++;
    if (remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_remainder: got %h expected 0", remainder);
    end
    step();
    tests_run++;
    if (ready !== 1'b0 || state_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL idle_no_en: ready=%b state=%0d expected ready=0 state=0", ready, state_o);
    end
  endtask

  task automatic test_basic();
    int edges;
    int held;
    start_and_wait(32'd100, 32'd7, 1'b0, edges);
    tests_run++;
    if (edges !== LAT) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d edges expected %0d", edges, LAT);
    end
    tests_run++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      tests_failed++;
      $display("FAIL basic_result: got q=%0d r=%0d expected q=14 r=2", quotient, remainder);
    end
    held = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ready) held++;
    end
    tests_run++;
    if (held !== 3) begin
      tests_failed++;
      $display("FAIL basic_ready_hold: ready high %0d of 3 cycles expected 3", held);
    end
    release_en();
    tests_run++;
    if (ready !== 1'b0 || state_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_ready_fall: ready=%b state=%0d expected ready=0 state=0", ready, state_o);
    end
    step();
    tests_run++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      tests_failed++;
      $display("FAIL basic_hold_idle: got q=%0d r=%0d expected q=14 r=2", quotient, remainder);
    end
  endtask

  task automatic test_extremes();
    int edges;
    start_and_wait(32'hFFFF_FFFF, 32'd1, 1'b0, edges);
    tests_run++;
    if (edges !== LAT || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL max_div_one: edges=%0d q=%h r=%h expected edges=%0d q=ffffffff r=0",
               edges, quotient, remainder, LAT);
    end
    release_en();
    start_and_wait(32'd5, 32'hFFFF_FFFF, 1'b0, edges);
    tests_run++;
    if (edges !== LAT || quotient !== 32'd0 || remainder !== 32'd5) begin
      tests_failed++;
      $display("FAIL small_div_max: edges=%0d q=%h r=%h expected edges=%0d q=0 r=5",
               edges, quotient, remainder, LAT);
    end
    release_en();
  endtask

  task automatic test_div_zero();
    int edges;
    start_and_wait(32'h1234_5678, 32'd0, 1'b0, edges);
    tests_run++;
    if (edges !== LAT_DZ) begin
      tests_failed++;
      $display("FAIL divzero_latency: got %0d edges expected %0d", edges, LAT_DZ);
    end
    tests_run++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL divzero_result: got q=%h r=%h expected q=ffffffff r=12345678",
               quotient, remainder);
    end
    release_en();
  endtask

  task automatic test_en_drop();
    int edges;
    a = 32'd1000;
    b = 32'd10;
    is_signed = 1'b0;
    en = 1'b1;
    edges = BOUND;
    for (int i = 1; i < BOUND; i++) begin
      step();
      if (i == 5) begin
        en = 1'b0;
        a = 32'd3;
        b = 32'd3;
      end
      if (ready) begin
        edges = i;
        break;
      end
    end
    tests_run++;
    if (edges !== LAT) begin
      tests_failed++;
      $display("FAIL endrop_latency: got %0d edges expected %0d", edges, LAT);
    end
    tests_run++;
    if (quotient !== 32'd100 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL endrop_result: got q=%0d r=%0d expected q=100 r=0", quotient, remainder);
    end
    step();
    tests_run++;
    if (ready !== 1'b0 || state_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL endrop_one_cycle: ready=%b state=%0d expected ready=0 state=0", ready, state_o);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    a = 32'd777;
    b = 32'd3;
    is_signed = 1'b0;
    en = 1'b1;
    seen = 0;
    // edge 1 -> LOAD, edge 2 -> ITER cycle 1, edge 11 -> ITER cycle 10
    for (int i = 0; i < 11; i++) begin
      step();
      if (ready) seen++;
    end
    tests_run++;
    if (state_o !== 3'd2) begin
      tests_failed++;
      $display("FAIL abort_in_iter: state=%0d expected 2", state_o);
    end
    nrst = 1'b0;
    en = 1'b0;
    step();
    nrst = 1'b1;
    tests_run++;
    if (state_o !== 3'd0 || ready !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL abort_cleared: state=%0d ready=%b q=%h r=%h expected all 0",
               state_o, ready, quotient, remainder);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready || state_o !== 3'd0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_result: %0d cycles with ready/active expected 0", seen);
    end
  endtask

  task automatic test_random();
    int edges;
    int bad_lat;
    int bad_val;
    int bad_inv;
    logic [31:0] ra, rb, eq, er;
    longint unsigned recon;
    bad_lat = 0;
    bad_val = 0;
    bad_inv = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      if (i < 20) rb = 32'd1 << $urandom_range(0, 31);
      model(ra, rb, 1'b0, eq, er);
      start_and_wait(ra, rb, 1'b0, edges);
      tests_run++;
      if (edges !== LAT) begin
        tests_failed++;
        bad_lat++;
        if (bad_lat <= 5)
          $display("FAIL rand_latency: a=%h b=%h got %0d edges expected %0d", ra, rb, edges, LAT);
      end
      tests_run++;
      if (quotient !== eq || remainder !== er) begin
        tests_failed++;
        bad_val++;
        if (bad_val <= 5)
          $display("FAIL rand_result: a=%h b=%h got q=%h r=%h expected q=%h r=%h",
                   ra, rb, quotient, remainder, eq, er);
      end
      recon = longint'(quotient) * longint'(rb) + longint'(remainder);
      tests_run++;
      if (recon !== longint'(ra) || !(remainder < rb)) begin
        tests_failed++;
        bad_inv++;
        if (bad_inv <= 5)
          $display("FAIL rand_invariant: a=%h b=%h q=%h r=%h got q*b+r=%h expected %h with r<b",
                   ra, rb, quotient, remainder, recon, ra);
      end
      release_en();
    end
  endtask

`ifdef DIV32_SIGNED_EN
  task automatic test_signed();
    int edges;
    logic [31:0] ra, rb, eq, er;
    start_and_wait(32'hFFFF_FFF9, 32'd2, 1'b1, edges);
    tests_run++;
    if (edges !== 35 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL signed_neg7_div2: edges=%0d q=%h r=%h expected edges=35 q=fffffffd r=ffffffff",
               edges, quotient, remainder);
    end
    release_en();
    start_and_wait(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, edges);
    tests_run++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL signed_overflow: q=%h r=%h expected q=80000000 r=0", quotient, remainder);
    end
    release_en();
    start_and_wait(32'hFFFF_FFF9, 32'd0, 1'b1, edges);
    tests_run++;
    if (edges !== LAT_DZ || quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFF9) begin
      tests_failed++;
      $display("FAIL signed_divzero: edges=%0d q=%h r=%h expected edges=2 q=ffffffff r=fffffff9",
               edges, quotient, remainder);
    end
    release_en();
    for (int i = 0; i < 50; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      if (rb == 32'd0) rb = 32'd3;
      model(ra, rb, 1'b1, eq, er);
      start_and_wait(ra, rb, 1'b1, edges);
      tests_run++;
      if (edges !== 35 || quotient !== eq || remainder !== er) begin
        tests_failed++;
        $display("FAIL signed_rand: a=%h b=%h edges=%0d q=%h r=%h expected edges=35 q=%h r=%h",
                 ra, rb, edges, quotient, remainder, eq, er);
      end
      release_en();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_en_drop();
    test_reset_abort();
    test_random();
`ifdef DIV32_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div32.md
Name: div32

Overview:
- Sequential radix-2 restoring divider: 32-bit dividend / 32-bit divisor, producing a 32-bit quotient and a 32-bit remainder at one quotient bit per clock.
- Inverse-operation companion to the shift-add multiplier in the user domain, with the same en/ready level handshake, so software drivers and bus wrappers handle both blocks identically.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; only 32 is supported; counter width is $clog2(WIDTH).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- nrst  input  1  reset, synchronous, active-low.
- en  input  1  level request; operation starts when en is high in IDLE.
- ready  output  1  result valid; held high until en goes low.
- is_signed  input  1  signed-mode select; used only with DIV32_SIGNED_EN.
- a  input  32  dividend, sampled in LOAD.
- b  input  32  divisor, sampled in LOAD.
- quotient  output  32  quotient register.
- remainder  output  32  remainder register.

Behaviour:
- Reset (nrst=0 at a rising edge): state=IDLE; ready, quotient, remainder, internal rem/div/q registers and bit counter all 0. Reset mid-operation aborts immediately and no result is produced.
- FSM states: IDLE, LOAD, ITER, FIXUP (present only with the macro), READY.
- IDLE -> LOAD when en=1. Otherwise stays in IDLE; ready=0.
- LOAD (1 cycle):
  - Latches a into q_reg, b into div_reg, and clears rem_reg (33 bits); bit_cnt=31.
  - If b==0: quotient=0xFFFFFFFF, remainder=a, next state READY.
  - Otherwise: next state ITER.
- ITER (exactly 32 cycles):
  - trial = {rem_reg[31:0], q_reg[31]} - {1'b0, div_reg} (33-bit).
  - If trial[32]==0: rem_reg=trial and q_reg={q_reg[30:0],1}.
  - Else: rem_reg={rem_reg[31:0],q_reg[31]} and q_reg={q_reg[30:0],0}.
  - bit_cnt decrements each cycle. On the cycle with bit_cnt==0, quotient<=q_next and remainder<=rem_next[31:0], then next state is READY (or FIXUP with the macro).
- READY:
  - ready=1 (registered; high for every cycle the state is READY).
  - Stays in READY while en=1; goes to IDLE when en=0.
  - ready falls on the edge that enters IDLE.
- Latency:
  - Normal: en sampled high in IDLE at edge N gives ready=1 after edge N+34.
  - Divide-by-zero: ready=1 after edge N+2.
- en dropped during LOAD/ITER is ignored. The operation completes, ready is high for exactly one cycle, then the FSM returns to IDLE.
- quotient/remainder hold their values from completion until the next LOAD updates them. They are not cleared on IDLE.
- Inputs a/b/is_signed may change after LOAD without effect.
- Illegal state encoding -> IDLE on the next edge, no output update.
- Unsigned invariant: a == quotient*b + remainder, with remainder < b for b != 0.

Optional Feature:
- Macro: DIV32_SIGNED_EN.
- With the macro, when is_signed=1:
  - LOAD loads |a| and |b| and records qneg=a[31]^b[31] and rneg=a[31].
  - After ITER, a FIXUP cycle negates quotient if qneg and remainder if rneg, then goes to READY. Normal latency becomes 35 edges.
  - Divide-by-zero still gives quotient=0xFFFFFFFF, remainder=a, ready after N+2 (no FIXUP).
  - 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0.
  - When is_signed=0 the FIXUP cycle still occurs with no negation, so latency is a constant 35.
- Without the macro: no FIXUP state, is_signed is ignored (port kept, unconnected internally), unsigned only, latency 34.

Test Plan:
- a=100, b=7, en held high -> ready rises after 34 edges; quotient=14, remainder=2; ready stays high until en=0, then falls on the next edge.
- a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0. Then a=5, b=0xFFFFFFFF -> quotient=0, remainder=5.
- a=0x12345678, b=0 -> ready after 2 edges; quotient=0xFFFFFFFF, remainder=0x12345678.
- Start a=1000, b=10; drop en after 5 cycles -> ready high for exactly 1 cycle with quotient=100, remainder=0; then IDLE. Start a second operation with nrst=0 at ITER cycle 10 -> all outputs 0, state IDLE, ready never asserts.
- Random directed sweep of 1000 unsigned pairs, b != 0 -> a == quotient*b + remainder and remainder < b for every pair.
- (DIV32_SIGNED_EN) is_signed=1:
  - a=-7 (0xFFFFFFF9), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1), latency 35.
  - a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
